// File: rtl/div_req_ctrl_if.sv
// Bundle of every handshake/bus signal around the divide request controller.
//   Op side     : flush, op_valid/op_ready, op_sel, op_w, src1, src2
//   Result side : res_valid/res_ready, res_data
//   Divider side: div_valid/div_ready, div_dividend, div_divisor, div_divw,
//                 div_signed, div_flush, div_out_valid, div_quotient, div_remainder
// Modports: slave  = the controller itself,
//           master = the surrounding pipeline plus divider (drives the controller's inputs).
interface div_req_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_sel;
  logic            op_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] res_data;
  logic            div_valid;
  logic            div_ready;
  logic [XLEN-1:0] div_dividend;
  logic [XLEN-1:0] div_divisor;
  logic            div_divw;
  logic            div_signed;
  logic            div_flush;
  logic            div_out_valid;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;

  modport slave (
    input  flush, op_valid, op_sel, op_w, src1, src2, res_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    output op_ready, res_valid, res_data, div_valid, div_dividend, div_divisor,
           div_divw, div_signed, div_flush
  );

  modport master (
    output flush, op_valid, op_sel, op_w, src1, src2, res_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    input  op_ready, res_valid, res_data, div_valid, div_dividend, div_divisor,
           div_divw, div_signed, div_flush
  );
endinterface

// File: rtl/div_req_ctrl.sv
// Divide/remainder request controller. Accepts one DIV/DIVU/REM/REMU (optionally word
// variant) op at a time, resolves divide-by-zero and signed overflow locally, otherwise
// issues a single start pulse to an iterative divider and returns the selected result.
// Ports:
//   clk    : clock, rising edge
//   rrst_n : asynchronous active-low reset
//   bus    : div_req_ctrl_if.slave (op, result and divider handshakes)
module div_req_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input logic            clk,
  input logic            rrst_n,
  div_req_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StDrain = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] dividend_q, divisor_q, res_q, res_d;
  logic            divw_q, signed_q, want_rem_q;

  logic            accept;
  logic            op_signed, op_rem;
  logic            div_zero, sgn_ovf, bypass;
  logic [XLEN-1:0] bypass_raw, bypass_res;
  logic [XLEN-1:0] div_raw, div_res;

  assign op_signed = ~bus.op_sel[0];
  assign op_rem    = bus.op_sel[1];

  assign bus.op_ready = (state_q == StIdle) && !bus.flush;
  assign accept       = bus.op_valid && bus.op_ready;

  // Special cases are judged on the raw inputs in the accept cycle so they never cost
  // a divider round trip.
  assign div_zero = bus.op_w ? (bus.src2[31:0] == 32'd0) : (bus.src2 == '0);
  assign sgn_ovf  = op_signed &&
                    (bus.op_w ? ((bus.src1[31:0] == 32'h8000_0000) &&
                                 (bus.src2[31:0] == 32'hFFFF_FFFF))
                              : ((bus.src1 == MinNeg) && (bus.src2 == AllOnes)));
  assign bypass   = div_zero || sgn_ovf;

  always_comb begin
    bypass_raw = '0;
    if (div_zero) begin
      bypass_raw = op_rem ? bus.src1 : AllOnes;
    end else begin
      bypass_raw = op_rem ? '0 : bus.src1;
    end
  end

  assign bypass_res = bus.op_w ? sext32(bypass_raw[31:0]) : bypass_raw;
  assign div_raw    = want_rem_q ? bus.div_remainder : bus.div_quotient;
  assign div_res    = divw_q ? sext32(div_raw[31:0]) : div_raw;

  // Next state and result capture.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bypass) begin
            state_d = StDone;
            res_d   = bypass_res;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (bus.div_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.flush) begin
          // A completion in the flush cycle means the divider is already idle.
          state_d = bus.div_out_valid ? StIdle : StDrain;
        end else if (bus.div_out_valid) begin
          state_d = StDone;
          res_d   = div_res;
        end
      end
      StDone: begin
        if (bus.flush || bus.res_ready) begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        if (bus.div_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= StIdle;
      res_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      divw_q     <= 1'b0;
      signed_q   <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (accept) begin
        dividend_q <= bus.src1;
        divisor_q  <= bus.src2;
        divw_q     <= bus.op_w;
        signed_q   <= op_signed;
        want_rem_q <= op_rem;
      end
    end
  end

  // REQ lasts until the pulse is issued, so div_valid can never repeat back to back.
  assign bus.div_valid    = (state_q == StReq) && bus.div_ready && !bus.flush;
  assign bus.div_flush    = (state_q == StWait) && bus.flush;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.div_divw     = divw_q;
  assign bus.div_signed   = signed_q;
  assign bus.res_valid    = (state_q == StDone);
  assign bus.res_data     = res_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed self-checking bench for div_req_ctrl. The bench plays the role of the divider.
module tb_div_req_ctrl;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] Ones = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Min  = 64'h8000_0000_0000_0000;

  logic clk;
  logic rrst_n;
  int   n_checks;
  int   n_fail;
  int   dv_count;
  int   dv_consec;
  logic dv_prev;

  div_req_ctrl_if #(.XLEN(XLEN)) bus ();

  div_req_ctrl #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses and back-to-back pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rrst_n) begin
      if (bus.div_valid) dv_count++;
      if (bus.div_valid && dv_prev) dv_consec++;
      dv_prev = bus.div_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op and hold it until the accepting edge has passed.
  task automatic issue(input logic [1:0] sel, input logic w, input logic [63:0] s1,
                       input logic [63:0] s2);
    int n;
    n = 0;
    while (!bus.op_ready && n < 20) begin
      tick();
      n++;
    end
    check_eq("issue_ready", {63'd0, bus.op_ready}, 64'd1);
    bus.op_valid = 1'b1;
    bus.op_sel   = sel;
    bus.op_w     = w;
    bus.src1     = s1;
    bus.src2     = s2;
    tick();
    bus.op_valid = 1'b0;
  endtask

  task automatic do_div_op(input string tag, input logic [1:0] sel, input logic w,
                           input logic [63:0] s1, input logic [63:0] s2,
                           input logic [63:0] q, input logic [63:0] r,
                           input logic [63:0] exp, input int hold);
    int dv0;
    dv0 = dv_count;
    issue(sel, w, s1, s2);
    check_eq({tag, "_dv_n1"}, {63'd0, bus.div_valid}, 64'd1);
    check_eq({tag, "_signed"}, {63'd0, bus.div_signed}, {63'd0, ~sel[0]});
    check_eq({tag, "_divw"}, {63'd0, bus.div_divw}, {63'd0, w});
    tick();
    check_eq({tag, "_dv_low"}, {63'd0, bus.div_valid}, 64'd0);
    check_eq({tag, "_dvd"}, bus.div_dividend, s1);
    check_eq({tag, "_dvs"}, bus.div_divisor, s2);
    tick();
    bus.div_out_valid = 1'b1;
    bus.div_quotient  = q;
    bus.div_remainder = r;
    tick();
    bus.div_out_valid = 1'b0;
    bus.div_quotient  = '0;
    bus.div_remainder = '0;
    check_eq({tag, "_rv"}, {63'd0, bus.res_valid}, 64'd1);
    check_eq({tag, "_res"}, bus.res_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq({tag, "_hold_rv"}, {63'd0, bus.res_valid}, 64'd1);
      check_eq({tag, "_hold_res"}, bus.res_data, exp);
      check_eq({tag, "_hold_ordy"}, {63'd0, bus.op_ready}, 64'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq({tag, "_rv_clr"}, {63'd0, bus.res_valid}, 64'd0);
    check_eq({tag, "_dv_cnt"}, 64'(dv_count - dv0), 64'd1);
  endtask

  task automatic do_bypass(input string tag, input logic [1:0] sel, input logic w,
                           input logic [63:0] s1, input logic [63:0] s2,
                           input logic [63:0] exp);
    int dv0;
    dv0 = dv_count;
    issue(sel, w, s1, s2);
    check_eq({tag, "_rv"}, {63'd0, bus.res_valid}, 64'd1);
    check_eq({tag, "_res"}, bus.res_data, exp);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check_eq({tag, "_dv_cnt"}, 64'(dv_count - dv0), 64'd0);
  endtask

  initial begin
    int dv0;
    n_checks = 0;
    n_fail   = 0;
    dv_count = 0;
    dv_consec = 0;
    dv_prev  = 1'b0;
    bus.flush = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_sel = 2'b00;
    bus.op_w = 1'b0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.res_ready = 1'b0;
    bus.div_ready = 1'b1;
    bus.div_out_valid = 1'b0;
    bus.div_quotient = '0;
    bus.div_remainder = '0;
    rrst_n = 1'b0;
    #23;
    check_eq("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    check_eq("rst_div_valid", {63'd0, bus.div_valid}, 64'd0);
    check_eq("rst_div_flush", {63'd0, bus.div_flush}, 64'd0);
    check_eq("rst_res_data", bus.res_data, 64'd0);
    check_eq("rst_dividend", bus.div_dividend, 64'd0);
    check_eq("rst_op_ready", {63'd0, bus.op_ready}, 64'd1);
    rrst_n = 1'b1;
    tick();

    // Flush in IDLE only masks op_ready.
    bus.flush = 1'b1;
    #1;
    check_eq("idle_flush_ordy", {63'd0, bus.op_ready}, 64'd0);
    bus.flush = 1'b0;
    #1;
    check_eq("idle_ordy", {63'd0, bus.op_ready}, 64'd1);

    // Divider-path ops.
    do_div_op("div_m20", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
              64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 0);
    do_div_op("remuw", 2'b11, 1'b1, 64'h1_0000_0007, 64'd2, 64'd3, 64'd1, 64'd1, 0);
    do_div_op("divuw", 2'b01, 1'b1, 64'h8000_0000, 64'd1, 64'h8000_0000, 64'd0,
              64'hFFFF_FFFF_8000_0000, 0);
    do_div_op("divu_big", 2'b01, 1'b0, Min, Ones, 64'd0, Min, 64'd0, 0);
    do_div_op("rem_hold", 2'b10, 1'b0, 64'd17, 64'd5, 64'd3, 64'd2, 64'd2, 5);

    // Bypass ops.
    do_bypass("divu_z", 2'b01, 1'b0, 64'd7, 64'd0, Ones);
    do_bypass("rem_z", 2'b10, 1'b0, 64'd5, 64'd0, 64'd5);
    do_bypass("divw_z", 2'b00, 1'b1, 64'd9, 64'h1_0000_0000, Ones);
    do_bypass("remuw_z", 2'b11, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hF_0000_0000,
              64'hFFFF_FFFF_9ABC_DEF0);
    do_bypass("div_ovf", 2'b00, 1'b0, Min, Ones, Min);
    do_bypass("remw_ovf", 2'b10, 1'b1, 64'h8000_0000, Ones, 64'd0);
    do_bypass("divw_ovf", 2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
              64'hFFFF_FFFF_8000_0000);

    // Stray completion in IDLE is ignored.
    bus.div_out_valid = 1'b1;
    tick();
    bus.div_out_valid = 1'b0;
    check_eq("idle_stray_rv", {63'd0, bus.res_valid}, 64'd0);

    // Flush 10 cycles into WAIT, late completion in DRAIN ignored.
    dv0 = dv_count;
    issue(2'b00, 1'b0, 64'd100, 64'd7);
    tick();
    bus.div_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    bus.flush = 1'b1;
    #1;
    check_eq("wflush_dflush", {63'd0, bus.div_flush}, 64'd1);
    tick();
    bus.flush = 1'b0;
    #1;
    check_eq("wflush_dflush_1cyc", {63'd0, bus.div_flush}, 64'd0);
    check_eq("drain_ordy", {63'd0, bus.op_ready}, 64'd0);
    bus.div_out_valid = 1'b1;
    bus.div_quotient  = 64'd14;
    tick();
    bus.div_out_valid = 1'b0;
    check_eq("drain_rv", {63'd0, bus.res_valid}, 64'd0);
    check_eq("drain_ordy2", {63'd0, bus.op_ready}, 64'd0);
    bus.div_ready = 1'b1;
    tick();
    check_eq("drain_exit_ordy", {63'd0, bus.op_ready}, 64'd1);
    check_eq("drain_exit_rv", {63'd0, bus.res_valid}, 64'd0);
    check_eq("wflush_dv_cnt", 64'(dv_count - dv0), 64'd1);

    // Flush in REQ while the divider is busy: no pulse, back to IDLE.
    dv0 = dv_count;
    bus.div_ready = 1'b0;
    issue(2'b01, 1'b0, 64'd50, 64'd5);
    check_eq("req_busy_dv", {63'd0, bus.div_valid}, 64'd0);
    bus.flush = 1'b1;
    bus.div_ready = 1'b1;
    #1;
    check_eq("req_flush_dv", {63'd0, bus.div_valid}, 64'd0);
    tick();
    bus.flush = 1'b0;
    #1;
    check_eq("req_flush_ordy", {63'd0, bus.op_ready}, 64'd1);
    check_eq("req_flush_dv_cnt", 64'(dv_count - dv0), 64'd0);

    // Flush coincident with completion in WAIT: result discarded.
    issue(2'b10, 1'b0, 64'd50, 64'd7);
    tick();
    bus.flush = 1'b1;
    bus.div_out_valid = 1'b1;
    bus.div_remainder = 64'd1;
    #1;
    check_eq("wcoinc_dflush", {63'd0, bus.div_flush}, 64'd1);
    tick();
    bus.flush = 1'b0;
    bus.div_out_valid = 1'b0;
    #1;
    check_eq("wcoinc_rv", {63'd0, bus.res_valid}, 64'd0);
    check_eq("wcoinc_ordy", {63'd0, bus.op_ready}, 64'd1);

    // Flush in DONE drops the result.
    issue(2'b01, 1'b0, 64'd3, 64'd0);
    check_eq("done_rv", {63'd0, bus.res_valid}, 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    check_eq("done_flush_rv", {63'd0, bus.res_valid}, 64'd0);
    check_eq("done_flush_ordy", {63'd0, bus.op_ready}, 64'd1);

    // Reset mid-WAIT abandons the op.
    issue(2'b00, 1'b0, 64'd40, 64'd8);
    tick();
    rrst_n = 1'b0;
    #1;
    check_eq("wrst_rv", {63'd0, bus.res_valid}, 64'd0);
    check_eq("wrst_dvd", bus.div_dividend, 64'd0);
    check_eq("wrst_res", bus.res_data, 64'd0);
    rrst_n = 1'b1;
    bus.div_out_valid = 1'b1;
    bus.div_quotient  = 64'd5;
    tick();
    bus.div_out_valid = 1'b0;
    check_eq("wrst_late_rv", {63'd0, bus.res_valid}, 64'd0);

    check_eq("dv_never_consec", 64'(dv_consec), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
